// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw switch pins in, debounced level and edge events out.
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] sw_toggle;

  modport master (
    output sw_raw,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  sw_toggle
  );

  modport slave (
    input  sw_raw,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output sw_toggle
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-channel 2-flop synchroniser, stability-counter debouncer and rise/fall pulse generator.
// Optional toggle latch on each rise is enabled by defining SW_DEBOUNCE_TOGGLE_EN.
module sw_debounce #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input logic          clk,
  input logic          rst_n,
  sw_debounce_if.slave sw_bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    sync1_d = sw_bus.sw_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        // Any return to the accepted level restarts the full stability window.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        db_d[i]   = sync2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync2_q[i];
        fall_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_bus.sw_db   = db_q;
  assign sw_bus.sw_rise = rise_q;
  assign sw_bus.sw_fall = fall_q;

`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q, toggle_d;

  // Flips on the same edge the accepted level rises.
  always_comb begin
    toggle_d = toggle_q ^ rise_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign sw_bus.sw_toggle = toggle_q;
`else
  assign sw_bus.sw_toggle = '0;
`endif

endmodule
